// File: rtl/cpu64_l3_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cpu64_l3_ctrl
// Purpose : Blocking L3 lookup/refill controller (16-way, 2048 sets, 64 B
//           lines) with dirty-victim writeback and 8-beat line refill.
// Revision: 1.0
// ============================================================================
module cpu64_l3_ctrl (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [63:0]  req_addr_i,
  input  logic         req_we_i,
  input  logic [7:0]   req_be_i,
  input  logic [63:0]  req_wdata_i,
  output logic         resp_valid_o,
  output logic [63:0]  resp_rdata_o,
  output logic         mem_req_valid_o,
  input  logic         mem_req_ready_i,
  output logic         mem_req_we_o,
  output logic [63:0]  mem_req_addr_o,
  output logic         mem_wvalid_o,
  input  logic         mem_wready_i,
  output logic [63:0]  mem_wdata_o,
  input  logic         mem_rvalid_i,
  input  logic [63:0]  mem_rdata_i,
  output logic [10:0]  arr_index_o,
  output logic [2:0]   arr_word_sel_o,
  output logic [3:0]   arr_way_sel_o,
  output logic         arr_write_en_o,
  output logic         arr_set_valid_o,
  output logic         arr_set_dirty_o,
  output logic [7:0]   arr_be_o,
  output logic [46:0]  arr_tag_o,
  output logic [63:0]  arr_wdata_o,
  input  logic [63:0]  arr_rdata_selected_i,
  input  logic [751:0] arr_tag_way_flat_i,
  input  logic [15:0]  arr_valid_way_i,
  input  logic [15:0]  arr_dirty_way_i
);

  localparam int TAG_W   = 47;
  localparam int INDEX_W = 11;
  localparam int WORD_W  = 3;
  localparam int WAYS    = 16;
  localparam int BEATS   = 8;

  localparam logic [WORD_W-1:0] c_last_beat = WORD_W'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOOKUP  = 3'd1,
    S_WB_REQ  = 3'd2,
    S_WB_DATA = 3'd3,
    S_RF_REQ  = 3'd4,
    S_RF_DATA = 3'd5
  } state_t;

  state_t              r_state;
  logic [TAG_W-1:0]    r_tag;
  logic [INDEX_W-1:0]  r_index;
  logic [WORD_W-1:0]   r_word;
  logic                r_we;
  logic [7:0]          r_be;
  logic [63:0]         r_wdata;
  logic [3:0]          r_victim;
  logic [3:0]          r_victim_ptr;
  logic [WORD_W-1:0]   r_beat;

  logic [TAG_W-1:0]    w_way_tag [WAYS];
  logic                w_hit;
  logic [3:0]          w_hit_way;
  logic                w_free;
  logic [3:0]          w_free_way;
  logic [3:0]          w_victim;
  logic                w_victim_dirty;
  logic                w_unused_addr;

  // Byte offset within the word never matters: requests are whole 64-bit words.
  assign w_unused_addr = ^req_addr_i[2:0];

  for (genvar g = 0; g < WAYS; g++) begin : g_way_tag
    assign w_way_tag[g] = arr_tag_way_flat_i[g*TAG_W +: TAG_W];
  end

  // Scan from the top way down so the lowest matching / free way wins.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_way  = '0;
    w_free     = 1'b0;
    w_free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (arr_valid_way_i[w] && (w_way_tag[w] == r_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = 4'(w);
      end
      if (!arr_valid_way_i[w]) begin
        w_free     = 1'b1;
        w_free_way = 4'(w);
      end
    end
  end

  assign w_victim       = w_free ? w_free_way : r_victim_ptr;
  assign w_victim_dirty = arr_valid_way_i[w_victim] && arr_dirty_way_i[w_victim];

  always_comb begin
    req_ready_o     = (r_state == S_IDLE);
    mem_req_valid_o = (r_state == S_WB_REQ) || (r_state == S_RF_REQ);
    mem_req_we_o    = (r_state == S_WB_REQ);
    mem_req_addr_o  = '0;
    if (r_state == S_WB_REQ) begin
      mem_req_addr_o = {w_way_tag[r_victim], r_index, 6'b0};
    end else if (r_state == S_RF_REQ) begin
      mem_req_addr_o = {r_tag, r_index, 6'b0};
    end
    mem_wvalid_o    = (r_state == S_WB_DATA);
    mem_wdata_o     = (r_state == S_WB_DATA) ? arr_rdata_selected_i : '0;

    arr_index_o     = r_index;
    arr_word_sel_o  = ((r_state == S_WB_DATA) || (r_state == S_RF_DATA)) ? r_beat : r_word;
    arr_way_sel_o   = (r_state == S_LOOKUP) ? w_hit_way : r_victim;
    arr_write_en_o  = 1'b0;
    arr_set_valid_o = 1'b0;
    arr_set_dirty_o = 1'b0;
    arr_be_o        = '0;
    arr_tag_o       = r_tag;
    arr_wdata_o     = '0;
    if ((r_state == S_LOOKUP) && w_hit && r_we) begin
      arr_write_en_o  = 1'b1;
      arr_set_valid_o = 1'b1;
      arr_set_dirty_o = 1'b1;
      arr_be_o        = r_be;
      arr_wdata_o     = r_wdata;
    end else if ((r_state == S_RF_DATA) && mem_rvalid_i) begin
      // Line stays invalid until its last beat lands.
      arr_write_en_o  = 1'b1;
      arr_set_valid_o = (r_beat == c_last_beat);
      arr_be_o        = 8'hFF;
      arr_wdata_o     = mem_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_tag        <= '0;
      r_index      <= '0;
      r_word       <= '0;
      r_we         <= 1'b0;
      r_be         <= '0;
      r_wdata      <= '0;
      r_victim     <= '0;
      r_victim_ptr <= '0;
      r_beat       <= '0;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
    end else begin
      resp_valid_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_tag   <= req_addr_i[63:17];
            r_index <= req_addr_i[16:6];
            r_word  <= req_addr_i[5:3];
            r_we    <= req_we_i;
            r_be    <= req_be_i;
            r_wdata <= req_wdata_i;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            resp_valid_o <= 1'b1;
            resp_rdata_o <= r_we ? 64'h0 : arr_rdata_selected_i;
            r_state      <= S_IDLE;
          end else begin
            r_victim <= w_victim;
            if (!w_free) begin
              r_victim_ptr <= r_victim_ptr + 4'd1;
            end
            r_state <= w_victim_dirty ? S_WB_REQ : S_RF_REQ;
          end
        end
        S_WB_REQ: begin
          if (mem_req_ready_i) begin
            r_state <= S_WB_DATA;
          end
        end
        S_WB_DATA: begin
          if (mem_wready_i) begin
            if (r_beat == c_last_beat) begin
              r_beat  <= '0;
              r_state <= S_RF_REQ;
            end else begin
              r_beat <= r_beat + 3'd1;
            end
          end
        end
        S_RF_REQ: begin
          if (mem_req_ready_i) begin
            r_state <= S_RF_DATA;
          end
        end
        S_RF_DATA: begin
          if (mem_rvalid_i) begin
            if (r_beat == c_last_beat) begin
              r_beat  <= '0;
              r_state <= S_LOOKUP;
            end else begin
              r_beat <= r_beat + 3'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu64_l3_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu64_l3_ctrl
// Purpose : Randomised bench for cpu64_l3_ctrl with array/memory models and a
//           set-level cache reference model.
// Revision: 1.0
// ============================================================================
module tb_cpu64_l3_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_n;
  logic         req_valid_i, req_ready_o, req_we_i;
  logic [63:0]  req_addr_i, req_wdata_i;
  logic [7:0]   req_be_i;
  logic         resp_valid_o;
  logic [63:0]  resp_rdata_o;
  logic         mem_req_valid_o, mem_req_ready_i, mem_req_we_o;
  logic [63:0]  mem_req_addr_o;
  logic         mem_wvalid_o, mem_wready_i;
  logic [63:0]  mem_wdata_o;
  logic         mem_rvalid_i;
  logic [63:0]  mem_rdata_i;
  logic [10:0]  arr_index_o;
  logic [2:0]   arr_word_sel_o;
  logic [3:0]   arr_way_sel_o;
  logic         arr_write_en_o, arr_set_valid_o, arr_set_dirty_o;
  logic [7:0]   arr_be_o;
  logic [46:0]  arr_tag_o;
  logic [63:0]  arr_wdata_o;
  logic [63:0]  arr_rdata_selected_i;
  logic [751:0] arr_tag_way_flat_i;
  logic [15:0]  arr_valid_way_i, arr_dirty_way_i;

  always #5 clk_i = ~clk_i;

  cpu64_l3_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_we_i(req_we_i), .req_be_i(req_be_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_wvalid_o(mem_wvalid_o), .mem_wready_i(mem_wready_i), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .arr_index_o(arr_index_o), .arr_word_sel_o(arr_word_sel_o), .arr_way_sel_o(arr_way_sel_o),
    .arr_write_en_o(arr_write_en_o), .arr_set_valid_o(arr_set_valid_o),
    .arr_set_dirty_o(arr_set_dirty_o), .arr_be_o(arr_be_o), .arr_tag_o(arr_tag_o),
    .arr_wdata_o(arr_wdata_o), .arr_rdata_selected_i(arr_rdata_selected_i),
    .arr_tag_way_flat_i(arr_tag_way_flat_i), .arr_valid_way_i(arr_valid_way_i),
    .arr_dirty_way_i(arr_dirty_way_i)
  );

  // Physical L3 arrays driven by the controller.
  bit [46:0] env_tag   [2048][16];
  bit        env_valid [2048][16];
  bit        env_dirty [2048][16];
  bit [63:0] env_data  [262144];

  always_comb begin
    arr_rdata_selected_i = env_data[{arr_index_o, arr_way_sel_o, arr_word_sel_o}];
    arr_tag_way_flat_i   = '0;
    arr_valid_way_i      = '0;
    arr_dirty_way_i      = '0;
    for (int w = 0; w < 16; w++) begin
      arr_tag_way_flat_i[w*47 +: 47] = env_tag[arr_index_o][w];
      arr_valid_way_i[w]             = env_valid[arr_index_o][w];
      arr_dirty_way_i[w]             = env_dirty[arr_index_o][w];
    end
  end

  always @(posedge clk_i) begin
    if (arr_write_en_o) begin
      env_tag[arr_index_o][arr_way_sel_o]   <= arr_tag_o;
      env_valid[arr_index_o][arr_way_sel_o] <= arr_set_valid_o;
      env_dirty[arr_index_o][arr_way_sel_o] <= arr_set_dirty_o;
      for (int b = 0; b < 8; b++)
        if (arr_be_o[b])
          env_data[{arr_index_o, arr_way_sel_o, arr_word_sel_o}][b*8 +: 8] <= arr_wdata_o[b*8 +: 8];
    end
  end

  // Backing memory (mm) and the architecturally current view of memory (gold).
  logic [63:0] mm   [logic [63:0]];
  logic [63:0] gold [logic [63:0]];

  function automatic logic [63:0] pat(input logic [63:0] wa);
    return {wa[31:0], ~wa[31:0]} ^ 64'h5A5A_0000_0000_A5A5;
  endfunction
  function automatic logic [63:0] mm_rd(input logic [63:0] wa);
    if (mm.exists(wa)) return mm[wa];
    return pat(wa);
  endfunction
  function automatic logic [63:0] gold_rd(input logic [63:0] wa);
    if (gold.exists(wa)) return gold[wa];
    return pat(wa);
  endfunction
  function automatic logic [63:0] addr_of(input int t, input int ix, input int w);
    return {47'(t), 11'(ix), 3'(w), 3'b0};
  endfunction

  // Set-level reference: which line sits in which way, plus the round-robin pointer.
  bit          m_valid [2048][16];
  bit          m_dirty [2048][16];
  logic [46:0] m_tag   [2048][16];
  int          m_ptr;
  bit          m_hit;
  logic [63:0] m_erd;
  logic [64:0] exp_req[$], q_req[$];
  logic [63:0] exp_wb[$],  q_wb[$];

  function automatic void model_access(input logic [63:0] a, input bit we,
                                       input logic [7:0] be, input logic [63:0] wd);
    logic [46:0] t;
    logic [10:0] ix;
    logic [63:0] wa, vl, cur;
    int way, v;
    t = a[63:17]; ix = a[16:6]; wa = {a[63:3], 3'b0};
    way = -1; v = -1;
    exp_req.delete(); exp_wb.delete();
    for (int w = 0; w < 16; w++)
      if (way < 0 && m_valid[ix][w] && m_tag[ix][w] == t) way = w;
    m_hit = (way >= 0);
    if (way < 0) begin
      for (int w = 0; w < 16; w++)
        if (v < 0 && !m_valid[ix][w]) v = w;
      if (v < 0) begin
        v = m_ptr;
        m_ptr = (m_ptr + 1) % 16;
      end
      if (m_valid[ix][v] && m_dirty[ix][v]) begin
        vl = {m_tag[ix][v], ix, 6'b0};
        exp_req.push_back({1'b1, vl});
        for (int i = 0; i < 8; i++) exp_wb.push_back(gold_rd(vl + 64'(i * 8)));
      end
      exp_req.push_back({1'b0, a[63:6], 6'b0});
      m_tag[ix][v] = t; m_valid[ix][v] = 1'b1; m_dirty[ix][v] = 1'b0;
      way = v;
    end
    m_erd = 64'h0;
    if (we) begin
      cur = gold_rd(wa);
      for (int b = 0; b < 8; b++) if (be[b]) cur[b*8 +: 8] = wd[b*8 +: 8];
      gold[wa] = cur;
      m_dirty[ix][way] = 1'b1;
    end else begin
      m_erd = gold_rd(wa);
    end
  endfunction

  // Memory responder: random request-ready delay, random wready, gaps in refill.
  bit auto_mem = 1'b1;
  int rf_abort_beat = -1;
  bit abort_hit = 1'b0;

  initial begin
    logic [63:0] la;
    bit lw;
    int n, guard;
    mem_req_ready_i = 1'b0; mem_wready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (auto_mem && rst_n && mem_req_valid_o) begin
        repeat ($urandom_range(0, 2)) @(negedge clk_i);
        mem_req_ready_i = 1'b1;
        la = mem_req_addr_o;
        lw = mem_req_we_o;
        q_req.push_back({lw, la});
        @(posedge clk_i); #1 mem_req_ready_i = 1'b0;
        if (lw) begin
          n = 0; guard = 0;
          while (n < 8 && guard < 400) begin
            @(negedge clk_i); guard++;
            mem_wready_i = 1'($urandom % 2);
            #1;
            if (mem_wvalid_o && mem_wready_i) begin
              q_wb.push_back(mem_wdata_o);
              mm[la + 64'(n * 8)] = mem_wdata_o;
              n++;
            end
          end
          @(posedge clk_i); #1 mem_wready_i = 1'b0;
        end else begin
          for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            if ($urandom % 3 == 0) begin
              mem_rvalid_i = 1'b0;
              @(negedge clk_i);
            end
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = mm_rd(la + 64'(i * 8));
            if (i == rf_abort_beat) begin
              abort_hit = 1'b1;
              wait (!rst_n);
              mem_rvalid_i = 1'b0;
              break;
            end
          end
          @(negedge clk_i); mem_rvalid_i = 1'b0;
        end
      end
    end
  end

  int errors = 0;
  int checks = 0;
  logic [63:0] o_rd;
  int o_lat, o_tdiff;
  bit o_rdy;

  task automatic run_txn(input logic [63:0] a, input bit we, input logic [7:0] be,
                         input logic [63:0] wd);
    int g;
    model_access(a, we, be, wd);
    q_req.delete(); q_wb.delete();
    @(negedge clk_i);
    req_addr_i = a; req_we_i = we; req_be_i = be; req_wdata_i = wd; req_valid_i = 1'b1;
    g = 0;
    while (!req_ready_o && g < 1000) begin @(negedge clk_i); g++; end
    @(posedge clk_i); #1 req_valid_i = 1'b0;
    o_lat = 0;
    while (o_lat < 1000) begin
      @(negedge clk_i); o_lat++;
      if (resp_valid_o) break;
    end
    o_rd  = resp_rdata_o;
    o_rdy = req_ready_o;
    o_tdiff = int'(q_req.size() != exp_req.size()) + int'(q_wb.size() != exp_wb.size());
    for (int i = 0; i < q_req.size(); i++)
      if (i < exp_req.size() && q_req[i] !== exp_req[i]) o_tdiff++;
    for (int i = 0; i < q_wb.size(); i++)
      if (i < exp_wb.size() && q_wb[i] !== exp_wb[i]) o_tdiff++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; req_we_i = 1'b0;
    req_be_i = '0; req_wdata_i = '0;
    repeat (3) @(negedge clk_i);
    checks++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || resp_rdata_o !== 64'h0) begin
      errors++;
      $display("FAIL reset_resp ready=%b valid=%b rdata=%h want 1/0/0", req_ready_o, resp_valid_o, resp_rdata_o);
    end
    checks++;
    if (mem_req_valid_o !== 1'b0 || mem_wvalid_o !== 1'b0 || arr_write_en_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mem reqv=%b wv=%b we=%b want 0/0/0", mem_req_valid_o, mem_wvalid_o, arr_write_en_o);
    end
    rst_n = 1'b1;
    m_ptr = 0;
  endtask

  task automatic test_cold_read;
    for (int i = 0; i < 8; i++) begin
      mm[64'h2_0040 + 64'(i * 8)]   = 64'h100 + 64'(i);
      gold[64'h2_0040 + 64'(i * 8)] = 64'h100 + 64'(i);
    end
    run_txn(64'h0000_0000_0002_0048, 1'b0, 8'h00, 64'h0);
    checks++;
    if (o_rd !== 64'h101 || q_req.size() != 1 || q_req[0] !== {1'b0, 64'h2_0040}) begin
      errors++;
      $display("FAIL cold_read rdata=%h reqs=%0d want 101 with one refill @20040", o_rd, q_req.size());
    end
    run_txn(64'h0000_0000_0002_0048, 1'b0, 8'h00, 64'h0);
    checks++;
    if (o_rd !== 64'h101 || o_lat != 2 || !o_rdy || q_req.size() != 0) begin
      errors++;
      $display("FAIL hit_read rdata=%h lat=%0d rdy=%b reqs=%0d want 101/2/1/0", o_rd, o_lat, o_rdy, q_req.size());
    end
  endtask

  task automatic test_write_hit;
    run_txn(64'h0002_0048, 1'b1, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD);
    checks++;
    if (o_rd !== 64'h0 || o_lat != 2 || !o_rdy || o_tdiff != 0) begin
      errors++;
      $display("FAIL write_hit rdata=%h lat=%0d rdy=%b tdiff=%0d want 0/2/1/0", o_rd, o_lat, o_rdy, o_tdiff);
    end
    checks++;
    if (env_dirty[1][0] !== 1'b1) begin
      errors++;
      $display("FAIL write_hit_dirty got=%b want 1", env_dirty[1][0]);
    end
    run_txn(64'h0002_0048, 1'b0, 8'h00, 64'h0);
    checks++;
    if (o_rd !== 64'h0000_0000_CCCC_DDDD || o_lat != 2) begin
      errors++;
      $display("FAIL write_readback got=%h lat=%0d want 00000000ccccdddd lat 2", o_rd, o_lat);
    end
  endtask

  task automatic test_eviction;
    for (int t = 2; t <= 21; t++) begin
      if (t == 17) run_txn(addr_of(4, 1, 0), 1'b1, 8'hF0, 64'h1234_5678_0000_0000);
      run_txn(addr_of(t, 1, t % 8), 1'b0, 8'h00, 64'h0);
      checks++;
      if (o_lat >= 1000 || o_rd !== m_erd || o_tdiff != 0) begin
        errors++;
        $display("FAIL evict_txn tag=%0d rdata=%h exp=%h tdiff=%0d lat=%0d", t, o_rd, m_erd, o_tdiff, o_lat);
      end
      if (t == 20) begin
        checks++;
        if (q_req.size() != 2 || q_req[0] !== {1'b1, 64'h8_0040} || q_wb.size() != 8) begin
          errors++;
          $display("FAIL evict_wb reqs=%0d first=%h beats=%0d want 2 / wb@80040 / 8", q_req.size(),
                   (q_req.size() > 0) ? q_req[0] : 65'h0, q_wb.size());
        end
      end
    end
    checks++;
    if (env_tag[1][4] !== 47'd21) begin
      errors++;
      $display("FAIL evict_ptr way4 tag=%0d want 21", env_tag[1][4]);
    end
  endtask

  task automatic test_wrap;
    for (int t = 22; t <= 33; t++) begin
      run_txn(addr_of(t, 1, 7 - (t % 8)), 1'b0, 8'h00, 64'h0);
      checks++;
      if (o_lat >= 1000 || o_rd !== m_erd || o_tdiff != 0) begin
        errors++;
        $display("FAIL wrap_txn tag=%0d rdata=%h exp=%h tdiff=%0d", t, o_rd, m_erd, o_tdiff);
      end
    end
    checks++;
    if (env_tag[1][15] !== 47'd32 || env_tag[1][0] !== 47'd33) begin
      errors++;
      $display("FAIL wrap_victims way15=%0d way0=%0d want 32/33", env_tag[1][15], env_tag[1][0]);
    end
  endtask

  task automatic test_random;
    logic [63:0] a;
    bit we;
    for (int n = 0; n < 120; n++) begin
      a  = addr_of($urandom_range(1, 24), ($urandom % 2) ? 1 : 5, $urandom_range(0, 7));
      we = 1'($urandom % 2);
      run_txn(a, we, 8'($urandom_range(1, 255)), {$urandom, $urandom});
      checks++;
      if (o_lat >= 1000 || o_rd !== m_erd || o_tdiff != 0) begin
        errors++;
        $display("FAIL rand_txn a=%h we=%b rdata=%h exp=%h tdiff=%0d lat=%0d", a, we, o_rd, m_erd, o_tdiff, o_lat);
      end
      if (m_hit) begin
        checks++;
        if (o_lat != 2 || !o_rdy) begin
          errors++;
          $display("FAIL rand_hit_latency a=%h lat=%0d rdy=%b want 2/1", a, o_lat, o_rdy);
        end
      end
    end
  endtask

  task automatic test_reset_midrefill;
    int g;
    logic [63:0] a;
    a = addr_of(3, 9, 2);
    rf_abort_beat = 4; abort_hit = 1'b0;
    @(negedge clk_i);
    req_addr_i = a; req_we_i = 1'b0; req_be_i = 8'h00; req_valid_i = 1'b1;
    @(posedge clk_i); #1 req_valid_i = 1'b0;
    g = 0;
    while (!abort_hit && g < 3000) begin #1; g++; end
    checks++;
    if (!abort_hit) begin
      errors++;
      $display("FAIL midrefill_reach beat4 not reached got=%b want 1", abort_hit);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || resp_rdata_o !== 64'h0 ||
        mem_req_valid_o !== 1'b0 || mem_wvalid_o !== 1'b0 || arr_write_en_o !== 1'b0) begin
      errors++;
      $display("FAIL midrefill_outputs rdy=%b rv=%b rd=%h mrv=%b wv=%b we=%b want 1/0/0/0/0/0",
               req_ready_o, resp_valid_o, resp_rdata_o, mem_req_valid_o, mem_wvalid_o, arr_write_en_o);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n = 1'b1; rf_abort_beat = -1; m_ptr = 0;
    checks++;
    if (env_valid[9][0] !== 1'b0) begin
      errors++;
      $display("FAIL midrefill_valid got=%b want 0", env_valid[9][0]);
    end
    run_txn(a, 1'b0, 8'h00, 64'h0);
    checks++;
    if (m_hit || q_req.size() != 1 || o_rd !== m_erd || o_tdiff != 0) begin
      errors++;
      $display("FAIL midrefill_reread reqs=%0d rdata=%h exp=%h want one refill", q_req.size(), o_rd, m_erd);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cold_read();
    test_write_hit();
    test_eviction();
    test_wrap();
    test_random();
    test_reset_midrefill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu64_l3_ctrl.md
Name:
cpu64_l3_ctrl

Overview:
Lookup/refill controller placed directly in front of the L3 data/tag/valid/dirty arrays (2 MiB, 16-way, 2048 sets, 64 B lines). It accepts single 64-bit word requests from L2, performs the tag compare on the arrays' combinational per-way outputs, and serves hits. On a miss it picks a victim, writes it back if dirty, refills the line from memory in 8 beats, then replays the request. Blocking, one request in flight.

Parameters:
None. Geometry is fixed: TAG_W=47, INDEX_W=11, WORD_W=3, WAYS=16, BEATS=8.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i / req_ready_o  in/out  1/1  L2 request handshake
req_addr_i  in  64  byte address; tag=[63:17], index=[16:6], word=[5:3], [2:0] ignored
req_we_i / req_be_i / req_wdata_i  in  1/8/64  write flag, byte enables, write data
resp_valid_o  out  1  one-cycle completion pulse for both reads and writes; no backpressure
resp_rdata_o  out  64  read data; 0 for writes
mem_req_valid_o / mem_req_ready_i  out/in  1/1  memory line-request handshake
mem_req_we_o / mem_req_addr_o  out  1/64  1=writeback, 0=refill; address is line-aligned ([5:0]=0)
mem_wvalid_o / mem_wready_i / mem_wdata_o  out/in/out  1/1/64  writeback beats, word 0 first
mem_rvalid_i / mem_rdata_i  in  1/64  refill beats, word 0 first; no backpressure
arr_index_o / arr_word_sel_o / arr_way_sel_o  out  11/3/4  array address
arr_write_en_o / arr_set_valid_o / arr_set_dirty_o  out  1/1/1  array write controls
arr_be_o / arr_tag_o / arr_wdata_o  out  8/47/64  array write payload
arr_rdata_selected_i  in  64  data word for the driven way/word
arr_tag_way_flat_i  in  16*47  per-way tags; way w at [w*47 +: 47]
arr_valid_way_i / arr_dirty_way_i  in  16/16  per-way valid and dirty bits

Behaviour:
- States: IDLE, LOOKUP, WB_REQ, WB_DATA, RF_REQ, RF_DATA. Async reset → IDLE; beat counter=0; victim_ptr=0; resp_valid_o=0; resp_rdata_o=0; mem_*valid_o=0; arr_write_en_o=0. A reset mid-transaction abandons it, and the memory side resets together with this block.
- req_ready_o = (state==IDLE), combinational. On accept, register addr/we/be/wdata and move to LOOKUP. arr_index_o and arr_word_sel_o are driven from the registered request in every state except WB_DATA/RF_DATA, where arr_word_sel_o = beat counter.
- LOOKUP: hit = any way with valid and tag match. Multiple matches are illegal; the lowest way wins. Hit read: resp_rdata_o <= arr_rdata_selected_i with arr_way_sel_o = hit way, resp_valid_o pulses next cycle, → IDLE. Hit write: array write in this cycle (be=req_be, tag unchanged, valid=1, dirty=1), resp pulses next cycle, → IDLE. Hit latency: accept in cycle A, response in cycle A+2, ready again in A+2.
- Miss: victim = lowest invalid way; if all 16 are valid, victim = victim_ptr and victim_ptr increments modulo 16 (15→0). Victim is registered. If valid and dirty → WB_REQ, else → RF_REQ.
- WB_REQ: mem_req_valid_o=1, we=1, addr={victim tag,index,6'b0}, held until mem_req_ready_i → WB_DATA.
- WB_DATA: arr_way_sel_o=victim; mem_wdata_o=arr_rdata_selected_i; mem_wvalid_o=1. Counter advances only on wvalid&&wready. Handshake at count 7 → RF_REQ, counter → 0.
- RF_REQ: valid=1, we=0, addr={req tag,index,6'b0}; on ready → RF_DATA.
- RF_DATA: each mem_rvalid_i writes mem_rdata_i to victim, word=counter, be=FF, tag=req tag, dirty=0, valid=0 on beats 0–6 and valid=1 on beat 7, so a partial line is never visible. After beat 7, counter → 0 and the FSM → LOOKUP (replay), which is guaranteed to hit. Write misses are write-allocate via this replay.
- arr_write_en_o is asserted only in the LOOKUP write-hit case and on RF_DATA beats.
- mem_req_valid_o / mem_wvalid_o must not drop before their handshake.

Test Plan:
- Cold read 0x0000_0000_0002_0048 → RF_REQ addr 0x...0002_0040 (index 1, tag 1). Refill beats 0..7 = 0x100+i. resp_rdata_o=0x101; second read of same address: resp at A+2, no memory traffic.
- Write hit be=0x0F, wdata=0xAAAA_BBBB_CCCC_DDDD over 0x101 → read back 0x0000_0000_CCCC_DDDD; dirty bit set.
- 17 distinct tags on one index, with way 3 dirty when victim_ptr=3 → WB_REQ addr = way-3 line, 8 beats with mem_wready_i toggling, then refill; victim_ptr becomes 4.
- Wrap: victim_ptr=15 on a full-set miss → victim 15, ptr → 0.
- Reset asserted during RF_DATA beat 4 → IDLE, all outputs 0, req_ready_o=1; the line stays invalid (no hit on re-read).
